async_fill_parser: RTL and testbench
====================================

ASYNC_FILL_PARSER -- requirements
Module: async_fill_parser

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all logic samples on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port in_dat, input, 132 bits: tagged burst word, [131:128] tag, [127:0] payload.
REQ-004 SHALL have ports in_valid (input, 1) and in_ready (output, 1): word accepted when both are high.
REQ-005 SHALL have fill outputs: fill_num 24, fill_type 2, num_fill_bursts 23, async_num_bursts 14, async_pre_trig 16, num_waveforms 23, channel_tag 12.
REQ-006 SHALL have waveform outputs: wfm_hdr_valid 1, wfm_index 23, wfm_start_adr 26.
REQ-007 SHALL have port smp_dat, output, 96 bits: eight 12-bit signed samples, oldest in [11:0].
REQ-008 SHALL have ports smp_valid (output, 1), smp_ready (input, 1) and smp_last (output, 1, last burst of a waveform).
REQ-009 SHALL have output fill_done (1-cycle pulse) and sticky error flags tag_err, seq_err, sign_err, len_err and cksum_err, 1 bit each.

Function
REQ-010 SHALL recognise tags 1 (fill header), 2 (waveform header), 3 (data) and 4 (checksum); any other tag is a tag error.
REQ-011 SHALL implement states IDLE, WFM_HDR, DATA, CKSUM and ERR.
REQ-012 IDLE: SHALL accept words and discard them until tag 1 arrives, then latch the fill fields and go to WFM_HDR.
REQ-013 SHALL unpack the fill header as follows:
- fill_num [23:0], fill_type [25:24], num_fill_bursts [49:27], async_num_bursts [63:50].
- async_pre_trig = {[102:99], [75:64]}.
- num_waveforms [98:76], channel_tag [121:110].
REQ-014 WFM_HDR: with waveforms remaining, SHALL expect tag 2; when the count reaches num_waveforms, SHALL expect tag 4 and go to CKSUM; num_waveforms=0 goes directly to CKSUM.
REQ-015 SHALL unpack the waveform header and pulse wfm_hdr_valid for 1 cycle:
- wfm_index = [74:52], wfm_start_adr = [51:26].
- wfm_hdr_valid pulses 1 cycle after the word is accepted.
REQ-016 SHALL set seq_err if any of these waveform-header checks fail (parsing continues):
- [13:0] equals the latched async_num_bursts.
- [25:14] equals async_pre_trig[11:0].
- [109:98] equals channel_tag.
- wfm_index equals the count of waveforms already received in this fill, starting at 0.
REQ-017 DATA: SHALL accept exactly async_num_bursts tag-3 words, then return to WFM_HDR; async_num_bursts=0 skips DATA.
REQ-018 SHALL strip the sign extension per 16-bit lane; sign_err sets if lane bits [15:12] are not all equal to lane bit [11].
REQ-019 SHALL present samples on a single output register: in_ready in DATA = !smp_valid || smp_ready; data stays stable while smp_valid && !smp_ready.
REQ-020 in_ready SHALL be 1 in IDLE, WFM_HDR, CKSUM and ERR.
REQ-021 SHALL require payload[127:126]=2'b01 on tags 1 and 2, else set tag_err.
REQ-022 SHALL accumulate a running XOR of payload[127:0] over every accepted word from the fill header through the last data word:
- cleared on acceptance of the fill header, which is XORed in as the first term.
- the checksum word itself is excluded.
REQ-023 CKSUM: on the tag-4 word, SHALL set cksum_err if the payload differs from the accumulator, then pulse fill_done 1 cycle later and go to IDLE.
REQ-024 SHALL count every accepted word from the fill header through the checksum inclusive; len_err sets at fill_done if the count does not equal num_fill_bursts.
REQ-025 SHALL handle an unexpected tag in WFM_HDR, DATA or CKSUM as follows:
- set tag_err and go to ERR.
- ERR discards words until tag 1, which is parsed as a new fill header (same cycle as IDLE).
REQ-026 SHALL clear error flags on acceptance of each fill header; the flags hold from fill_done until the next fill header.
REQ-027 SHALL use 23-bit waveform and burst counters with no wrap; the 14-bit data counter SHALL compare against async_num_bursts.

Reset
REQ-028 rst SHALL force state to IDLE and clear every output to 0, including smp_valid, fill_done, all flags, all latched fields and all counters.
REQ-029 rst asserted mid-fill SHALL abandon the fill with no fill_done; in_ready SHALL be 1 in the cycle after reset deasserts.

Structure
REQ-030 Package async_fmt_pkg SHALL hold the tag constants (1-4), the header-tag value 2'b01, all field bit positions and the state enum; the matching adc_dat_mux_ASYNC-side encoder SHALL share it.
REQ-031 The checksum accumulator SHALL be sub-module async_cksum_acc (clear, update, 128-bit data, 128-bit sum); the state machine and unpacking stay in the top module.

Verification
REQ-032 Nominal fill: fill_num=0x00ABCD, 2 waveforms × 3 bursts, num_fill_bursts=10, correct checksum -> six smp_valid words, two wfm_hdr_valid pulses (index 0, 1), fill_done, all flags 0.
REQ-033 num_waveforms=0, words = fill header + checksum (equal to the header payload), num_fill_bursts=2 -> fill_done, no samples, no errors.
REQ-034 Checksum payload with bit 0 flipped -> fill_done with cksum_err=1 only.
REQ-035 A tag-2 word arrives where a data burst is expected -> tag_err=1, ERR state; next tag-1 word -> new fill parsed cleanly and tag_err cleared.
REQ-036 smp_ready held low for 5 cycles mid-waveform -> in_ready=0, smp_dat stable, no bursts lost; lane value 0x7800 -> sign_err=1.
REQ-037 rst asserted during DATA of waveform 1 -> all outputs 0 the next cycle, no fill_done; a following fill parses without errors.

Source files
------------

// File: rtl/async_fmt_pkg.sv
// async_fmt_pkg: tag codes, burst-word field positions, fill header layout and parser states shared by parser and encoder
package async_fmt_pkg;
    localparam logic [3:0] TAG_FILL  = 4'd1;
    localparam logic [3:0] TAG_WFM   = 4'd2;
    localparam logic [3:0] TAG_DATA  = 4'd3;
    localparam logic [3:0] TAG_CKSUM = 4'd4;
    localparam logic [1:0] HDR_MARK  = 2'b01;
    localparam int TAG_LSB  = 128;
    localparam int MARK_LSB = 126;
    localparam int FH_FILL_NUM     = 0;
    localparam int FH_FILL_TYPE    = 24;
    localparam int FH_NUM_BURSTS   = 27;
    localparam int FH_ASYNC_BURSTS = 50;
    localparam int FH_PRE_TRIG_LO  = 64;
    localparam int FH_NUM_WFM      = 76;
    localparam int FH_PRE_TRIG_HI  = 99;
    localparam int FH_CHANNEL      = 110;
    localparam int WH_ASYNC_BURSTS = 0;
    localparam int WH_PRE_TRIG     = 14;
    localparam int WH_START_ADR    = 26;
    localparam int WH_INDEX        = 52;
    localparam int WH_CHANNEL      = 98;
    localparam int LANES  = 8;
    localparam int LANE_W = 16;
    localparam int SMP_W  = 12;

    typedef enum logic [2:0] {ST_IDLE, ST_WFM_HDR, ST_DATA, ST_CKSUM, ST_ERR} state_t;

    typedef struct packed {
        logic [23:0] fill_num;
        logic [1:0]  fill_type;
        logic [22:0] num_fill_bursts;
        logic [13:0] async_num_bursts;
        logic [15:0] async_pre_trig;
        logic [22:0] num_waveforms;
        logic [11:0] channel_tag;
    } fill_t;

    function automatic fill_t unpack_fill(input logic [127:0] p);
        fill_t f;
        f.fill_num         = p[FH_FILL_NUM +: 24];
        f.fill_type        = p[FH_FILL_TYPE +: 2];
        f.num_fill_bursts  = p[FH_NUM_BURSTS +: 23];
        f.async_num_bursts = p[FH_ASYNC_BURSTS +: 14];
        f.async_pre_trig   = {p[FH_PRE_TRIG_HI +: 4], p[FH_PRE_TRIG_LO +: 12]};
        f.num_waveforms    = p[FH_NUM_WFM +: 23];
        f.channel_tag      = p[FH_CHANNEL +: 12];
        return f;
    endfunction
endpackage

// File: rtl/async_cksum_acc.sv
// async_cksum_acc: running 128-bit XOR accumulator
// clear restarts the sum, update XORs data in; clear+update loads data as the first term.
module async_cksum_acc (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         update,
    input  logic [127:0] data,
    output logic [127:0] sum
);
    logic [127:0] sum_q, sum_d;

    always_comb sum_d = (clear ? '0 : sum_q) ^ (update ? data : '0);

    always_ff @(posedge clk) begin
        if (rst) sum_q <= '0;
        else     sum_q <= sum_d;
    end

    assign sum = sum_q;
endmodule

// File: rtl/async_fill_parser.sv
// async_fill_parser: parses tagged async-fill burst words into fill/waveform headers and 8x12-bit sample words
// in_*: 132-bit tagged words (valid/ready); fill_*: latched fill header fields; wfm_*: waveform header pulse;
// smp_*: unpacked samples (valid/ready, last burst of waveform); fill_done pulse and sticky error flags.
module async_fill_parser
    import async_fmt_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [131:0] in_dat,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [23:0]  fill_num,
    output logic [1:0]   fill_type,
    output logic [22:0]  num_fill_bursts,
    output logic [13:0]  async_num_bursts,
    output logic [15:0]  async_pre_trig,
    output logic [22:0]  num_waveforms,
    output logic [11:0]  channel_tag,
    output logic         wfm_hdr_valid,
    output logic [22:0]  wfm_index,
    output logic [25:0]  wfm_start_adr,
    output logic [95:0]  smp_dat,
    output logic         smp_valid,
    input  logic         smp_ready,
    output logic         smp_last,
    output logic         fill_done,
    output logic         tag_err,
    output logic         seq_err,
    output logic         sign_err,
    output logic         len_err,
    output logic         cksum_err
);
    state_t       state_q, state_d;
    fill_t        fill_q, fill_d;
    logic [22:0]  wfm_index_q, wfm_index_d, wfm_cnt_q, wfm_cnt_d, burst_cnt_q, burst_cnt_d, burst_inc;
    logic [25:0]  wfm_start_adr_q, wfm_start_adr_d;
    logic [13:0]  data_cnt_q, data_cnt_d, data_nxt;
    logic [95:0]  smp_dat_q, smp_dat_d;
    logic         smp_valid_q, smp_valid_d, smp_last_q, smp_last_d;
    logic         wfm_hdr_valid_q, wfm_hdr_valid_d, fill_done_q, fill_done_d;
    logic         tag_err_q, tag_err_d, seq_err_q, seq_err_d, sign_err_q, sign_err_d;
    logic         len_err_q, len_err_d, cksum_err_q, cksum_err_d;
    logic         acc_clear, acc_update, accept, hdr_ok, bad_tag, in_fill;
    logic [127:0] acc_sum, pay;
    logic [3:0]   tag;

    assign tag       = in_dat[TAG_LSB +: 4];
    assign pay       = in_dat[127:0];
    assign hdr_ok    = pay[MARK_LSB +: 2] == HDR_MARK;
    assign in_ready  = (state_q == ST_DATA) ? (!smp_valid_q || smp_ready) : 1'b1;
    assign accept    = in_valid && in_ready;
    assign in_fill   = state_q inside {ST_WFM_HDR, ST_DATA, ST_CKSUM};
    // burst counter saturates rather than wrapping
    assign burst_inc = (burst_cnt_q == '1) ? burst_cnt_q : burst_cnt_q + 23'd1;
    assign data_nxt  = data_cnt_q + 14'd1;

    async_cksum_acc u_cksum (
        .clk    (clk),
        .rst    (rst),
        .clear  (acc_clear),
        .update (acc_update),
        .data   (pay),
        .sum    (acc_sum)
    );

    always_comb begin
        state_d         = state_q;
        fill_d          = fill_q;
        wfm_index_d     = wfm_index_q;
        wfm_start_adr_d = wfm_start_adr_q;
        wfm_cnt_d       = wfm_cnt_q;
        data_cnt_d      = data_cnt_q;
        burst_cnt_d     = (accept && in_fill) ? burst_inc : burst_cnt_q;
        smp_valid_d     = smp_valid_q && !smp_ready;
        smp_dat_d       = smp_dat_q;
        smp_last_d      = smp_last_q;
        wfm_hdr_valid_d = 1'b0;
        fill_done_d     = 1'b0;
        tag_err_d       = tag_err_q;
        seq_err_d       = seq_err_q;
        sign_err_d      = sign_err_q;
        len_err_d       = len_err_q;
        cksum_err_d     = cksum_err_q;
        acc_clear       = 1'b0;
        acc_update      = 1'b0;
        bad_tag         = 1'b0;
        if (accept) begin
            case (state_q)
                ST_IDLE, ST_ERR: if (tag == TAG_FILL) begin
                    fill_d      = unpack_fill(pay);
                    tag_err_d   = !hdr_ok;
                    seq_err_d   = 1'b0;
                    sign_err_d  = 1'b0;
                    len_err_d   = 1'b0;
                    cksum_err_d = 1'b0;
                    wfm_cnt_d   = '0;
                    burst_cnt_d = 23'd1;
                    acc_clear   = 1'b1;
                    acc_update  = 1'b1;
                    state_d     = (fill_d.num_waveforms == '0) ? ST_CKSUM : ST_WFM_HDR;
                end
                ST_WFM_HDR: if (tag == TAG_WFM) begin
                    wfm_index_d     = pay[WH_INDEX +: 23];
                    wfm_start_adr_d = pay[WH_START_ADR +: 26];
                    wfm_hdr_valid_d = 1'b1;
                    tag_err_d       = tag_err_q | !hdr_ok;
                    seq_err_d       = seq_err_q
                                    | (pay[WH_ASYNC_BURSTS +: 14] != fill_q.async_num_bursts)
                                    | (pay[WH_PRE_TRIG +: 12] != fill_q.async_pre_trig[11:0])
                                    | (pay[WH_CHANNEL +: 12] != fill_q.channel_tag)
                                    | (pay[WH_INDEX +: 23] != wfm_cnt_q);
                    wfm_cnt_d       = wfm_cnt_q + 23'd1;
                    data_cnt_d      = '0;
                    acc_update      = 1'b1;
                    state_d         = (fill_q.async_num_bursts != '0) ? ST_DATA :
                                      (wfm_cnt_d == fill_q.num_waveforms) ? ST_CKSUM : ST_WFM_HDR;
                end else bad_tag = 1'b1;
                ST_DATA: if (tag == TAG_DATA) begin
                    for (int i = 0; i < LANES; i++) begin
                        smp_dat_d[SMP_W*i +: SMP_W] = pay[LANE_W*i +: SMP_W];
                        // upper nibble of each lane must be pure sign extension of bit 11
                        if (pay[LANE_W*i+SMP_W +: 4] != {4{pay[LANE_W*i+SMP_W-1]}}) sign_err_d = 1'b1;
                    end
                    smp_valid_d = 1'b1;
                    smp_last_d  = data_nxt == fill_q.async_num_bursts;
                    data_cnt_d  = data_nxt;
                    acc_update  = 1'b1;
                    state_d     = !smp_last_d ? ST_DATA :
                                  (wfm_cnt_q == fill_q.num_waveforms) ? ST_CKSUM : ST_WFM_HDR;
                end else bad_tag = 1'b1;
                ST_CKSUM: if (tag == TAG_CKSUM) begin
                    cksum_err_d = pay != acc_sum;
                    len_err_d   = burst_inc != fill_q.num_fill_bursts;
                    fill_done_d = 1'b1;
                    state_d     = ST_IDLE;
                end else bad_tag = 1'b1;
                default: ;
            endcase
        end
        if (bad_tag) begin
            tag_err_d = 1'b1;
            state_d   = ST_ERR;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            fill_q          <= '0;
            wfm_index_q     <= '0;
            wfm_start_adr_q <= '0;
            wfm_cnt_q       <= '0;
            data_cnt_q      <= '0;
            burst_cnt_q     <= '0;
            smp_valid_q     <= 1'b0;
            smp_dat_q       <= '0;
            smp_last_q      <= 1'b0;
            wfm_hdr_valid_q <= 1'b0;
            fill_done_q     <= 1'b0;
            tag_err_q       <= 1'b0;
            seq_err_q       <= 1'b0;
            sign_err_q      <= 1'b0;
            len_err_q       <= 1'b0;
            cksum_err_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            fill_q          <= fill_d;
            wfm_index_q     <= wfm_index_d;
            wfm_start_adr_q <= wfm_start_adr_d;
            wfm_cnt_q       <= wfm_cnt_d;
            data_cnt_q      <= data_cnt_d;
            burst_cnt_q     <= burst_cnt_d;
            smp_valid_q     <= smp_valid_d;
            smp_dat_q       <= smp_dat_d;
            smp_last_q      <= smp_last_d;
            wfm_hdr_valid_q <= wfm_hdr_valid_d;
            fill_done_q     <= fill_done_d;
            tag_err_q       <= tag_err_d;
            seq_err_q       <= seq_err_d;
            sign_err_q      <= sign_err_d;
            len_err_q       <= len_err_d;
            cksum_err_q     <= cksum_err_d;
        end
    end

    assign fill_num         = fill_q.fill_num;
    assign fill_type        = fill_q.fill_type;
    assign num_fill_bursts  = fill_q.num_fill_bursts;
    assign async_num_bursts = fill_q.async_num_bursts;
    assign async_pre_trig   = fill_q.async_pre_trig;
    assign num_waveforms    = fill_q.num_waveforms;
    assign channel_tag      = fill_q.channel_tag;
    assign wfm_hdr_valid    = wfm_hdr_valid_q;
    assign wfm_index        = wfm_index_q;
    assign wfm_start_adr    = wfm_start_adr_q;
    assign smp_dat          = smp_dat_q;
    assign smp_valid        = smp_valid_q;
    assign smp_last         = smp_last_q;
    assign fill_done        = fill_done_q;
    assign tag_err          = tag_err_q;
    assign seq_err          = seq_err_q;
    assign sign_err         = sign_err_q;
    assign len_err          = len_err_q;
    assign cksum_err        = cksum_err_q;
endmodule

// File: tb/tb_async_fill_parser.sv
// tb_async_fill_parser: randomized fills built from the format rules, scoreboard checked on every output event
module tb_async_fill_parser;
    logic         clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_ready, smp_ready = 1'b1;
    logic [131:0] in_dat = '0;
    logic [23:0]  fill_num;
    logic [1:0]   fill_type;
    logic [22:0]  num_fill_bursts, num_waveforms, wfm_index;
    logic [13:0]  async_num_bursts;
    logic [15:0]  async_pre_trig;
    logic [11:0]  channel_tag;
    logic         wfm_hdr_valid, smp_valid, smp_last, fill_done;
    logic [25:0]  wfm_start_adr;
    logic [95:0]  smp_dat, snap;
    logic         tag_err, seq_err, sign_err, len_err, cksum_err;
    logic         stall_req = 1'b0;
    int           total = 0, passed = 0, sn;
    logic [96:0]  exp_smp[$];
    logic [48:0]  exp_wfm[$];
    logic [118:0] exp_done[$];

    async_fill_parser dut (
        .clk(clk), .rst(rst), .in_dat(in_dat), .in_valid(in_valid), .in_ready(in_ready),
        .fill_num(fill_num), .fill_type(fill_type), .num_fill_bursts(num_fill_bursts),
        .async_num_bursts(async_num_bursts), .async_pre_trig(async_pre_trig),
        .num_waveforms(num_waveforms), .channel_tag(channel_tag),
        .wfm_hdr_valid(wfm_hdr_valid), .wfm_index(wfm_index), .wfm_start_adr(wfm_start_adr),
        .smp_dat(smp_dat), .smp_valid(smp_valid), .smp_ready(smp_ready), .smp_last(smp_last),
        .fill_done(fill_done), .tag_err(tag_err), .seq_err(seq_err), .sign_err(sign_err),
        .len_err(len_err), .cksum_err(cksum_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    task automatic miss(input string nm);
        total++;
        $display("FAIL %s: output seen with no expectation queued", nm);
    endtask

    // scoreboard monitor: pops an expectation for every output event
    always @(negedge clk) if (!rst) begin
        if (smp_valid && smp_ready) begin
            if (exp_smp.size() == 0) miss("smp");
            else chk("smp", {smp_last, smp_dat}, exp_smp.pop_front());
        end
        if (wfm_hdr_valid) begin
            if (exp_wfm.size() == 0) miss("wfm_hdr");
            else chk("wfm_hdr", {wfm_index, wfm_start_adr}, exp_wfm.pop_front());
        end
        if (fill_done) begin
            if (exp_done.size() == 0) miss("fill_done");
            else chk("fill_done", {tag_err, seq_err, sign_err, len_err, cksum_err, fill_num, fill_type,
                     num_fill_bursts, async_num_bursts, async_pre_trig, num_waveforms, channel_tag},
                     exp_done.pop_front());
        end
    end

    // sample sink: random backpressure, or a directed 5-cycle stall once a sample is waiting
    initial forever begin
        @(posedge clk); #1;
        if (stall_req) begin
            smp_ready = 1'b0;
            sn = 0;
            while (!smp_valid && sn < 300) begin @(posedge clk); #1; sn++; end
            snap = smp_dat;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                chk("stall_in_ready", in_ready, 0);
                chk("stall_valid", smp_valid, 1);
                chk("stall_hold", smp_dat, snap);
                @(posedge clk); #1;
            end
            stall_req = 1'b0;
        end else smp_ready = $urandom_range(0, 3) != 0;
    end

    task automatic send(input logic [3:0] tag, input logic [127:0] pay);
        int n = 0;
        logic a;
        repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
        in_dat   = {tag, pay};
        in_valid = 1'b1;
        do begin
            @(negedge clk); a = in_ready;
            @(posedge clk); n++;
        end while (!a && n < 2000);
        #1 in_valid = 1'b0;
        if (!a) begin total++; $display("FAIL send_timeout: tag %0d not accepted", tag); end
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_smp.size() + exp_wfm.size() + exp_done.size()) != 0 && n < 1000) begin
            @(posedge clk); n++;
        end
        #1 chk("drain_pending", exp_smp.size() + exp_wfm.size() + exp_done.size(), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_ctrl", {smp_valid, smp_last, fill_done, wfm_hdr_valid, tag_err, seq_err, sign_err, len_err, cksum_err}, 0);
        chk("rst_fields", {fill_num, fill_type, num_fill_bursts, async_num_bursts, async_pre_trig, num_waveforms, channel_tag}, 0);
        chk("rst_wfm_smp", {wfm_index, wfm_start_adr, smp_dat}, 0);
        exp_smp.delete(); exp_wfm.delete(); exp_done.delete();
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);
        @(posedge clk); #1;
    endtask

    // mode: 0 clean, 1 checksum bit0 flipped, 2 sign violation, 3 bad wfm index,
    // 4 wrong num_fill_bursts, 5 tag-2 where data expected, 6 reset during waveform 1 data
    task automatic run_fill(input int nwf, input int nb, input int mode, input logic [23:0] fn);
        logic [127:0] hp, wp, dp, sum;
        logic [95:0]  ed;
        logic [22:0]  nfb, idx;
        logic [15:0]  pt, lane;
        logic [11:0]  ch, s;
        logic [25:0]  adr;
        logic [1:0]   ft;
        hp  = {$urandom, $urandom, $urandom, $urandom};
        pt  = 16'($urandom);
        ch  = 12'($urandom);
        ft  = 2'($urandom);
        nfb = 23'(2 + nwf * (1 + nb) + (mode == 4 ? 1 : 0));
        hp[127:126] = 2'b01;
        hp[23:0]    = fn;
        hp[25:24]   = ft;
        hp[49:27]   = nfb;
        hp[63:50]   = 14'(nb);
        hp[75:64]   = pt[11:0];
        hp[98:76]   = 23'(nwf);
        hp[102:99]  = pt[15:12];
        hp[121:110] = ch;
        send(4'd1, hp);
        sum = hp;
        for (int k = 0; k < nwf; k++) begin
            wp  = {$urandom, $urandom, $urandom, $urandom};
            idx = (mode == 3 && k == 1) ? 23'd5 : 23'(k);
            adr = 26'($urandom);
            wp[127:126] = 2'b01;
            wp[13:0]    = 14'(nb);
            wp[25:14]   = pt[11:0];
            wp[51:26]   = adr;
            wp[74:52]   = idx;
            wp[109:98]  = ch;
            exp_wfm.push_back({idx, adr});
            send(4'd2, wp);
            sum ^= wp;
            for (int j = 0; j < nb; j++) begin
                if (mode == 5 && k == nwf - 1 && j == 1) begin
                    send(4'd2, wp);
                    @(negedge clk);
                    chk("err_tag_err", tag_err, 1);
                    chk("err_in_ready", in_ready, 1);
                    @(posedge clk); #1;
                    return;
                end
                if (mode == 6 && k == 1 && j == 1) begin
                    do_reset();
                    return;
                end
                for (int l = 0; l < 8; l++) begin
                    s    = 12'($urandom);
                    lane = {{4{s[11]}}, s};
                    if (mode == 2 && k == 0 && j == 1 && l == 0) begin lane = 16'h7800; s = 12'h800; end
                    dp[16*l +: 16] = lane;
                    ed[12*l +: 12] = s;
                end
                exp_smp.push_back({j == nb - 1, ed});
                send(4'd3, dp);
                sum ^= dp;
            end
        end
        exp_done.push_back({1'b0, mode == 3, mode == 2, mode == 4, mode == 1,
                            fn, ft, nfb, 14'(nb), pt, 23'(nwf), ch});
        send(4'd4, mode == 1 ? sum ^ 128'd1 : sum);
        drain();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ctrl", {smp_valid, smp_last, fill_done, wfm_hdr_valid, tag_err, seq_err, sign_err, len_err, cksum_err}, 0);
        chk("reset_fields", {fill_num, num_fill_bursts, async_num_bursts, num_waveforms, wfm_index, smp_dat}, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", in_ready, 1);
        @(posedge clk); #1;
        run_fill(2, 3, 0, 24'h00ABCD);
        run_fill(0, 3, 0, 24'($urandom));
        run_fill(2, 3, 1, 24'($urandom));
        run_fill(2, 3, 5, 24'($urandom));
        drain();
        run_fill(1, 2, 0, 24'($urandom));
        stall_req = 1'b1;
        run_fill(2, 6, 2, 24'($urandom));
        run_fill(3, 2, 3, 24'($urandom));
        run_fill(2, 2, 4, 24'($urandom));
        run_fill(2, 3, 6, 24'($urandom));
        run_fill(2, 3, 0, 24'($urandom));
        run_fill(2, 0, 0, 24'($urandom));
        for (int r = 0; r < 6; r++)
            run_fill($urandom_range(0, 3), $urandom_range(0, 4), 0, 24'($urandom));
        repeat (5) @(posedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", passed, total + 1);
        $fatal(1, "watchdog");
    end
endmodule
